// File: rtl/serializer_ctrl_pkg.sv
// Shared types and constants for the vector-to-word serializer sequencer.
package serializer_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2
  } ser_state_t;

  localparam int unsigned PERF_W = 32;

endpackage

// File: rtl/serializer_ctrl.sv
// Sequences update/shift strobes so each vector streams out as INPUT_SIZE consecutive words.
// Optional perf counters are built when SERIALIZER_CTRL_PERF_EN is defined.
module serializer_ctrl
  import serializer_ctrl_pkg::*;
#(
  parameter int unsigned INPUT_SIZE = 8,
  parameter int unsigned VEC_W      = 16,
  parameter int unsigned IDX_W      = $clog2(INPUT_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VEC_W-1:0] num_vectors,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serializer_update,
  output logic             serializer_shift,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_index,
  output logic             out_first,
  output logic             out_last,
  output logic             busy,
  output logic             done
`ifdef SERIALIZER_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_active,
  output logic [PERF_W-1:0] perf_bubble
`endif
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(INPUT_SIZE - 1);

  ser_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VEC_W-1:0] vectors_left_q, vectors_left_d;
  logic             done_q, done_d;
  logic             last_elem;

  assign last_elem = (idx_q == LastIdx);

  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    vectors_left_d    = vectors_left_q;
    done_d            = 1'b0;
    in_ready          = 1'b0;
    serializer_update = 1'b0;
    serializer_shift  = 1'b0;
    out_valid         = 1'b0;
    out_index         = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_vectors != '0) begin
            vectors_left_d = num_vectors;
            idx_d          = '0;
            state_d        = StLoad;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Serializer passes element 0 straight through on the load cycle.
          serializer_update = 1'b1;
          out_valid         = 1'b1;
          vectors_left_d    = vectors_left_q - VEC_W'(1);
          idx_d             = IDX_W'(1);
          state_d           = StShift;
        end
      end
      StShift: begin
        out_valid        = 1'b1;
        out_index        = idx_q;
        serializer_shift = ~last_elem;
        idx_d            = idx_q + IDX_W'(1);
        if (last_elem) begin
          idx_d = '0;
          if (vectors_left_q == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      vectors_left_q <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      vectors_left_q <= vectors_left_d;
      done_q         <= done_d;
    end
  end

  assign out_first = out_valid & (out_index == '0);
  assign out_last  = out_valid & (out_index == LastIdx);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

`ifdef SERIALIZER_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_active_q, perf_bubble_q;
  logic              start_accepted;

  assign start_accepted = (state_q == StIdle) & start;

  always_ff @(posedge clk) begin
    if (rst || start_accepted) begin
      perf_active_q <= '0;
      perf_bubble_q <= '0;
    end else begin
      if (out_valid && (perf_active_q != '1)) begin
        perf_active_q <= perf_active_q + PERF_W'(1);
      end
      if ((state_q == StLoad) && !in_valid && (perf_bubble_q != '1)) begin
        perf_bubble_q <= perf_bubble_q + PERF_W'(1);
      end
    end
  end

  assign perf_active = perf_active_q;
  assign perf_bubble = perf_bubble_q;
`endif

endmodule

// File: tb/tb_serializer_ctrl.sv
// Scoreboard bench for serializer_ctrl: INPUT_SIZE=4 instance (a) and INPUT_SIZE=2 instance (b).
module tb_serializer_ctrl;

  typedef struct {
    int   idx;
    logic upd;
    logic sh;
    logic first;
    logic last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start_a, start_b, in_valid;
  logic [15:0] num_vectors;

  logic       in_ready_a, upd_a, sh_a, ov_a, first_a, last_a, busy_a, done_a;
  logic [1:0] idx_a;
  logic       in_ready_b, upd_b, sh_b, ov_b, first_b, last_b, busy_b, done_b;
  logic [0:0] idx_b;
`ifdef SERIALIZER_CTRL_PERF_EN
  logic [31:0] perf_active_a, perf_bubble_a, perf_active_b, perf_bubble_b;
`endif

  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  serializer_ctrl #(.INPUT_SIZE(4), .VEC_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .num_vectors(num_vectors), .in_valid(in_valid),
    .in_ready(in_ready_a), .serializer_update(upd_a), .serializer_shift(sh_a),
    .out_valid(ov_a), .out_index(idx_a), .out_first(first_a), .out_last(last_a),
    .busy(busy_a), .done(done_a)
`ifdef SERIALIZER_CTRL_PERF_EN
    , .perf_active(perf_active_a), .perf_bubble(perf_bubble_a)
`endif
  );

  serializer_ctrl #(.INPUT_SIZE(2), .VEC_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .num_vectors(num_vectors), .in_valid(in_valid),
    .in_ready(in_ready_b), .serializer_update(upd_b), .serializer_shift(sh_b),
    .out_valid(ov_b), .out_index(idx_b), .out_first(first_b), .out_last(last_b),
    .busy(busy_b), .done(done_b)
`ifdef SERIALIZER_CTRL_PERF_EN
    , .perf_active(perf_active_b), .perf_bubble(perf_bubble_b)
`endif
  );

  // Expected per-word strobes and markers for element i of an n-element vector.
  function automatic exp_t mk(int i, int n);
    exp_t e;
    e.idx   = i;
    e.upd   = (i == 0);
    e.sh    = (i > 0) && (i < n - 1);
    e.first = (i == 0);
    e.last  = (i == n - 1);
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0; num_vectors = '0;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready_a, upd_a, sh_a, ov_a, first_a, last_a, busy_a, done_a, idx_a} !== 10'b0) begin
      bad++;
      $display("FAIL reset_a outputs=%b want all zero",
               {in_ready_a, upd_a, sh_a, ov_a, first_a, last_a, busy_a, done_a, idx_a});
    end
    total++;
    if ({in_ready_b, upd_b, sh_b, ov_b, first_b, last_b, busy_b, done_b, idx_b} !== 9'b0) begin
      bad++;
      $display("FAIL reset_b outputs=%b want all zero",
               {in_ready_b, upd_b, sh_b, ov_b, first_b, last_b, busy_b, done_b, idx_b});
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy_a, ov_a, in_ready_a, done_a} !== 4'b0) begin
      bad++;
      $display("FAIL idle_after_reset busy/ov/ready/done=%b want 0000",
               {busy_a, ov_a, in_ready_a, done_a});
    end
  endtask

  task automatic test_single();
    exp_t e;
    int   pops = 0;
    int   dones = 0;
    for (int i = 0; i < 4; i++) q.push_back(mk(i, 4));
    @(posedge clk); #1 start_a = 1'b1; num_vectors = 16'd1; in_valid = 1'b1;
    @(negedge clk);
    total++;
    if (busy_a !== 1'b0 || ov_a !== 1'b0) begin
      bad++; $display("FAIL single_t0 busy=%b out_valid=%b want 0 0", busy_a, ov_a);
    end
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1 start_a = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        total++;
        if (busy_a !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want 1", busy_a); end
      end
      if (ov_a === 1'b1 && q.size() != 0) begin
        e = q.pop_front(); pops++; total++;
        if (c != pops || idx_a !== 2'(e.idx) || upd_a !== e.upd || sh_a !== e.sh ||
            first_a !== e.first || last_a !== e.last) begin
          bad++;
          $display("FAIL single_word c=%0d got idx=%0d upd=%b sh=%b f=%b l=%b want c=%0d idx=%0d upd=%b sh=%b f=%b l=%b",
                   c, idx_a, upd_a, sh_a, first_a, last_a, pops, e.idx, e.upd, e.sh, e.first, e.last);
        end
      end else begin
        total++;
        if (ov_a !== 1'b0 || upd_a !== 1'b0 || sh_a !== 1'b0) begin
          bad++; $display("FAIL single_idle c=%0d ov/upd/sh=%b%b%b want 000", c, ov_a, upd_a, sh_a);
        end
      end
      if (done_a === 1'b1) begin
        dones++; total++;
        if (c != 5 || busy_a !== 1'b0) begin
          bad++; $display("FAIL single_done at c=%0d busy=%b want c=5 busy=0", c, busy_a);
        end
      end
    end
    total++;
    if (dones != 1 || q.size() != 0) begin
      bad++; $display("FAIL single_count dones=%0d left=%0d want 1 0", dones, q.size());
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   pops = 0;
    int   dones = 0;
    for (int v = 0; v < 3; v++) for (int i = 0; i < 4; i++) q.push_back(mk(i, 4));
    @(posedge clk); #1 start_a = 1'b1; num_vectors = 16'd3; in_valid = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1 start_a = 1'b0;
      @(negedge clk);
      if (ov_a === 1'b1 && q.size() != 0) begin
        e = q.pop_front(); pops++; total++;
        if (c != pops || idx_a !== 2'(e.idx) || upd_a !== e.upd || sh_a !== e.sh ||
            first_a !== e.first || last_a !== e.last) begin
          bad++;
          $display("FAIL b2b_word c=%0d got idx=%0d upd=%b sh=%b f=%b l=%b want c=%0d idx=%0d upd=%b sh=%b f=%b l=%b",
                   c, idx_a, upd_a, sh_a, first_a, last_a, pops, e.idx, e.upd, e.sh, e.first, e.last);
        end
      end else begin
        total++;
        if (ov_a !== 1'b0 || upd_a !== 1'b0 || sh_a !== 1'b0) begin
          bad++; $display("FAIL b2b_idle c=%0d ov/upd/sh=%b%b%b want 000", c, ov_a, upd_a, sh_a);
        end
      end
      if (done_a === 1'b1) begin
        dones++; total++;
        if (c != 13 || busy_a !== 1'b0) begin
          bad++; $display("FAIL b2b_done at c=%0d busy=%b want c=13 busy=0", c, busy_a);
        end
      end
    end
    total++;
    if (dones != 1 || pops != 12) begin
      bad++; $display("FAIL b2b_count dones=%0d words=%0d want 1 12", dones, pops);
    end
  endtask

  task automatic test_bubbles();
    exp_t e;
    int   pops = 0;
    int   dones = 0;
    for (int v = 0; v < 2; v++) for (int i = 0; i < 4; i++) q.push_back(mk(i, 4));
    @(posedge clk); #1 start_a = 1'b1; num_vectors = 16'd2; in_valid = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1 start_a = 1'b0; in_valid = !(c == 5 || c == 6);
      @(negedge clk);
      if (ov_a === 1'b1 && q.size() != 0) begin
        e = q.pop_front(); pops++; total++;
        if (c != (pops <= 4 ? pops : pops + 2) || idx_a !== 2'(e.idx) || upd_a !== e.upd ||
            sh_a !== e.sh || first_a !== e.first || last_a !== e.last) begin
          bad++;
          $display("FAIL bubble_word c=%0d got idx=%0d upd=%b sh=%b want idx=%0d upd=%b sh=%b",
                   c, idx_a, upd_a, sh_a, e.idx, e.upd, e.sh);
        end
      end else begin
        total++;
        if (ov_a !== 1'b0 || upd_a !== 1'b0 || sh_a !== 1'b0) begin
          bad++; $display("FAIL bubble_idle c=%0d ov/upd/sh=%b%b%b want 000", c, ov_a, upd_a, sh_a);
        end
      end
      if (c == 5 || c == 6) begin
        total++;
        if (in_ready_a !== 1'b1 || busy_a !== 1'b1) begin
          bad++; $display("FAIL bubble_gap c=%0d ready=%b busy=%b want 1 1", c, in_ready_a, busy_a);
        end
      end
      if (done_a === 1'b1) begin
        dones++; total++;
        if (c != 11) begin bad++; $display("FAIL bubble_done at c=%0d want c=11", c); end
      end
    end
    total++;
    if (dones != 1 || pops != 8) begin
      bad++; $display("FAIL bubble_count dones=%0d words=%0d want 1 8", dones, pops);
    end
`ifdef SERIALIZER_CTRL_PERF_EN
    total++;
    if (perf_bubble_a !== 32'd2 || perf_active_a !== 32'd8) begin
      bad++;
      $display("FAIL perf bubble=%0d active=%0d want 2 8", perf_bubble_a, perf_active_a);
    end
`endif
    in_valid = 1'b1;
  endtask

  task automatic test_zero_length();
    @(posedge clk); #1 start_a = 1'b1; num_vectors = 16'd0; in_valid = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) begin @(posedge clk); #1 start_a = 1'b0; end
      @(negedge clk);
      total++;
      if (busy_a !== 1'b0 || ov_a !== 1'b0 || upd_a !== 1'b0 || sh_a !== 1'b0 ||
          done_a !== (c == 1)) begin
        bad++;
        $display("FAIL zero_len c=%0d busy=%b ov=%b upd=%b sh=%b done=%b want 0 0 0 0 %0d",
                 c, busy_a, ov_a, upd_a, sh_a, done_a, (c == 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    @(posedge clk); #1 start_a = 1'b1; num_vectors = 16'd2; in_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1 start_a = 1'b0; rst = (c == 3);
      @(negedge clk);
      if (c == 3) begin
        total++;
        if (idx_a !== 2'd2 || sh_a !== 1'b1) begin
          bad++; $display("FAIL rstmid_pre idx=%0d sh=%b want 2 1", idx_a, sh_a);
        end
      end
      if (c >= 4) begin
        total++;
        if ({in_ready_a, upd_a, sh_a, ov_a, first_a, last_a, busy_a, done_a, idx_a} !== 10'b0) begin
          bad++;
          $display("FAIL rstmid_post c=%0d outputs=%b want all zero", c,
                   {in_ready_a, upd_a, sh_a, ov_a, first_a, last_a, busy_a, done_a, idx_a});
        end
      end
    end
    @(posedge clk); #1 start_a = 1'b1; num_vectors = 16'd1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1 start_a = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        total++;
        if (upd_a !== 1'b1 || idx_a !== 2'd0 || busy_a !== 1'b1) begin
          bad++; $display("FAIL rstmid_restart upd=%b idx=%0d busy=%b want 1 0 1", upd_a, idx_a, busy_a);
        end
      end
      if (done_a === 1'b1) begin
        dones++; total++;
        if (c != 5) begin bad++; $display("FAIL rstmid_done at c=%0d want c=5", c); end
      end
    end
    total++;
    if (dones != 1) begin bad++; $display("FAIL rstmid_count dones=%0d want 1", dones); end
  endtask

  task automatic test_size2_ignored_start();
    exp_t e;
    int   pops = 0;
    int   dones = 0;
    for (int v = 0; v < 3; v++) for (int i = 0; i < 2; i++) q.push_back(mk(i, 2));
    @(posedge clk); #1 start_b = 1'b1; num_vectors = 16'd3; in_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1 start_b = (c == 2); num_vectors = (c == 2) ? 16'd5 : 16'd3;
      @(negedge clk);
      if (ov_b === 1'b1 && q.size() != 0) begin
        e = q.pop_front(); pops++; total++;
        if (c != pops || idx_b !== 1'(e.idx) || upd_b !== e.upd || sh_b !== e.sh ||
            first_b !== e.first || last_b !== e.last) begin
          bad++;
          $display("FAIL size2_word c=%0d got idx=%0d upd=%b sh=%b f=%b l=%b want idx=%0d upd=%b sh=%b f=%b l=%b",
                   c, idx_b, upd_b, sh_b, first_b, last_b, e.idx, e.upd, e.sh, e.first, e.last);
        end
      end else begin
        total++;
        if (ov_b !== 1'b0 || upd_b !== 1'b0 || sh_b !== 1'b0 || busy_b !== 1'b0) begin
          bad++;
          $display("FAIL size2_idle c=%0d ov/upd/sh/busy=%b%b%b%b want 0000", c, ov_b, upd_b, sh_b, busy_b);
        end
      end
      if (done_b === 1'b1) begin
        dones++; total++;
        if (c != 7) begin bad++; $display("FAIL size2_done at c=%0d want c=7", c); end
      end
    end
    total++;
    if (dones != 1 || pops != 6) begin
      bad++; $display("FAIL size2_count dones=%0d words=%0d want 1 6", dones, pops);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bubbles();
    test_zero_length();
    test_reset_mid();
    test_size2_ignored_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serializer_ctrl.md
# serializer_ctrl

Sequencer for the vector-to-word serializer in the accelerator datapath. It accepts a frame of `num_vectors` parallel vectors from the producing stage, one at a time. For each vector it drives the serializer's update and shift strobes so that the vector's `INPUT_SIZE` elements leave the serial port on consecutive cycles. It also emits word-valid, index and first/last markers to the downstream MAC stage, and signals frame completion.

## Interface
- `INPUT_SIZE`, default 8: elements per vector. Must be ≥ 2.
- `VEC_W`, default 16: width of the frame-length input.
- `IDX_W`, default `$clog2(INPUT_SIZE)`: element-index width (derived).
- `clk`  in  1: single clock, all state updates on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a frame. Sampled only in IDLE.
- `num_vectors`  in  VEC_W: vectors in the frame. Sampled with `start`.
- `in_valid`  in  1: producer presents a vector on the serializer's parallel input.
- `in_ready`  out  1: controller can accept a vector this cycle.
- `serializer_update`  out  1: load strobe to the serializer. Equals `in_valid & in_ready`.
- `serializer_shift`  out  1: shift strobe to the serializer.
- `out_valid`  out  1: the serializer's serial output carries a valid element this cycle.
- `out_index`  out  IDX_W: index of the current element, 0..INPUT_SIZE-1.
- `out_first`, `out_last`  out  1 each: element 0, and element INPUT_SIZE-1.
- `busy`  out  1: high whenever the state is not IDLE.
- `done`  out  1: one-cycle frame-complete pulse.

## Operation
- **States:** IDLE, LOAD, SHIFT.
- **IDLE**
  - On `start` with `num_vectors` ≠ 0: latch `vectors_left = num_vectors` and go to LOAD.
  - On `start` with `num_vectors` = 0: no transfers occur, and `done` pulses on the next cycle.
- **LOAD**
  - `in_ready` = 1.
  - If `in_valid`: assert `serializer_update` and `out_valid` with `out_index` = 0 (the serializer passes element 0 straight through). Decrement `vectors_left`, set `idx` = 1, go to SHIFT.
  - If `in_valid` is low: wait in LOAD (bubble).
- **SHIFT**
  - `in_ready` = 0.
  - `out_valid` = 1 and `out_index` = `idx`.
  - `serializer_shift` = 1 only when `idx` < INPUT_SIZE-1. It is 0 on the last element, so with INPUT_SIZE = 2 shift is never asserted.
  - `idx` increments each cycle.
  - At `idx` = INPUT_SIZE-1: if `vectors_left` = 0, go to IDLE and pulse `done` on the next cycle; otherwise go to LOAD.
- **No mid-vector stalls.** The serializer loses its contents on any cycle with neither strobe, so once loaded, a vector streams out unbroken. Downstream must accept every `out_valid` cycle.
- **No overlap.** `serializer_update` is never asserted in the same cycle as an element from a previous vector, because its pass-through would corrupt that element.
- `start` outside IDLE is ignored.
- `in_valid` outside LOAD is ignored, since `in_ready` = 0.

## Timing
- **Reset values:** state IDLE; `idx`, `vectors_left` = 0.
- **Outputs after reset:** `in_ready`, `serializer_update`, `serializer_shift`, `out_valid`, `out_first`, `out_last`, `busy` and `done` are all 0; `out_index` = 0.
- **Combinational outputs:**
  - `in_ready`, `serializer_update` and `out_valid` in LOAD depend on state and `in_valid` only.
  - `serializer_shift` and `out_*` in SHIFT are decoded from `idx`.
- **Frame start:** `start` at cycle t gives LOAD, with `busy` = 1, at t+1.
- **Per vector:** exactly INPUT_SIZE output cycles (the update cycle plus INPUT_SIZE-1 SHIFT cycles).
- **Back-to-back:** with `in_valid` held high, LOAD follows the last element immediately. Throughput is 1 word/cycle, with no gap between vectors.
- **Frame end:** `done` is registered. It rises the cycle after the last element of the last vector, and `busy` = 0 in that cycle.
- **Reset mid-frame:** immediate return to IDLE on the next edge. No `done` pulse is produced, and counters clear.

## Configuration
- Macro: `SERIALIZER_CTRL_PERF_EN`.
- **Defined:** adds output ports `perf_active` (32 bits, counts cycles with `out_valid`) and `perf_bubble` (32 bits, counts LOAD cycles with `in_valid` = 0).
  - Both clear on `rst` and on an accepted `start`.
  - Both saturate at all-ones.
- **Undefined:** the ports and counters are absent, and functional behaviour is identical.

## Structure
- Shared accelerator package holds:
  - the `ser_state_t` enum (IDLE, LOAD, SHIFT);
  - the `PERF_W` = 32 constant.
- Single module with no sub-modules. The perf counter pair is inline logic under the macro.

## Test plan
- **Single vector:** INPUT_SIZE=4, `num_vectors`=1, `in_valid` high.
  - Update strobe at t+1.
  - Shift at t+2 and t+3, none at t+4.
  - `out_index` 0,1,2,3; `done` at t+5.
- **Back-to-back:** `num_vectors`=3 with `in_valid` always high.
  - 12 consecutive `out_valid` cycles.
  - `out_first` at indices 0, 4 and 8 of the stream.
  - Exactly one `done`.
- **Bubbles:** `in_valid` low for 2 cycles between vectors.
  - `out_valid` = 0 and no strobes during the gap.
  - `perf_bubble` = 2 with the macro defined.
- **Zero-length frame:** `num_vectors`=0 gives `done` the next cycle, `busy` never high, and no strobes.
- **Reset mid-frame:** `rst` during SHIFT at index 2.
  - All outputs 0 the next cycle, and no `done`.
  - A new `start` then runs normally.
- **INPUT_SIZE=2 and ignored start:** `serializer_shift` is never asserted, and `start` pulsed while busy has no effect.
